// File: rtl/riscv_types.sv
// Shared AXI response/burst encodings used by the core and the memories
// on its external AXI port.
package riscv_types;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // Only single-beat requests are served; FIXED is accepted because the
  // load/store master leaves ax*burst at zero.
  function automatic logic axi_single_beat_ok(input logic [7:0] len, input logic [1:0] burst);
    return (len == 8'd0) && ((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR));
  endfunction

endpackage

// File: rtl/axi_sram_responder_ram.sv
// Single-port DEPTH_WORDS x 32 SRAM with per-byte write enables and a
// 1-cycle registered read; one memory array per byte lane.
module axi_sram_responder_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic             rd_zero,
  output logic [31:0]      rdata
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          mem[addr] <= wdata[gi*8 +: 8];
        end
      end

      // Output register reset doubles as the zero-data path for rejected reads.
      always_ff @(posedge clk) begin
        if (rst || (re && rd_zero)) begin
          q_reg <= 8'h00;
        end else if (re) begin
          q_reg <= mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/axi_sram_responder.sv
// Single-outstanding AXI4 subordinate in front of a word SRAM with an
// optional exclusive monitor (AXI_SRAM_RESPONDER_EXCLUSIVE_EN).
module axi_sram_responder
  import riscv_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ID_W        = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     awaddr,
  input  logic [ID_W-1:0] awid,
  input  logic [7:0]      awlen,
  input  logic [1:0]      awburst,
  input  logic            awlock,
  input  logic            wvalid,
  output logic            wready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  output logic            bvalid,
  input  logic            bready,
  output logic [1:0]      bresp,
  output logic [ID_W-1:0] bid,
  input  logic            arvalid,
  output logic            arready,
  input  logic [31:0]     araddr,
  input  logic [ID_W-1:0] arid,
  input  logic [7:0]      arlen,
  input  logic [1:0]      arburst,
  input  logic            arlock,
  output logic            rvalid,
  input  logic            rready,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic [ID_W-1:0] rid,
  output logic            rlast
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_W_COLLECT, ST_W_EXEC, ST_B_RESP, ST_R_EXEC, ST_R_RESP
  } state_t;

  state_t state_reg, state_next;

  logic [IDX_W-1:0] aw_idx_reg, ar_idx_reg;
  logic [ID_W-1:0]  awid_reg, arid_reg;
  logic             aw_ok_reg, ar_ok_reg, awlock_reg, arlock_reg;
  logic             aw_have_reg, w_have_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       wstrb_reg;

  logic        bvalid_reg, rvalid_reg, rlast_reg;
  logic [1:0]  bresp_reg, rresp_reg;
  logic [ID_W-1:0] bid_reg, rid_reg;

  logic       aw_hs, w_hs, ar_hs;
  logic       wr_en, ram_we;
  logic [1:0] wr_resp, rd_resp;
  logic [IDX_W-1:0] ram_addr;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[31:IDX_W+2], awaddr[1:0], araddr[31:IDX_W+2], araddr[1:0]};

  assign awready = !rst && ((state_reg == ST_IDLE) || ((state_reg == ST_W_COLLECT) && !aw_have_reg));
  assign wready  = !rst && ((state_reg == ST_IDLE) || ((state_reg == ST_W_COLLECT) && !w_have_reg));
  assign arready = !rst && (state_reg == ST_IDLE) && !awvalid && !wvalid;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (aw_hs && w_hs) begin
          state_next = ST_W_EXEC;
        end else if (aw_hs || w_hs) begin
          state_next = ST_W_COLLECT;
        end else if (ar_hs) begin
          state_next = ST_R_EXEC;
        end
      end
      ST_W_COLLECT: if (aw_hs || w_hs) state_next = ST_W_EXEC;
      ST_W_EXEC:    state_next = ST_B_RESP;
      ST_B_RESP:    if (bready) state_next = ST_IDLE;
      ST_R_EXEC:    state_next = ST_R_RESP;
      ST_R_RESP:    if (rready) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_idx_reg <= awaddr[IDX_W+1:2];
      awid_reg   <= awid;
      aw_ok_reg  <= axi_single_beat_ok(awlen, awburst);
      awlock_reg <= awlock;
    end
    if (w_hs) begin
      wdata_reg <= wdata;
      wstrb_reg <= wstrb;
    end
    if (ar_hs) begin
      ar_idx_reg <= araddr[IDX_W+1:2];
      arid_reg   <= arid;
      ar_ok_reg  <= axi_single_beat_ok(arlen, arburst);
      arlock_reg <= arlock;
    end
    if (rst || (state_reg == ST_W_EXEC)) begin
      aw_have_reg <= 1'b0;
      w_have_reg  <= 1'b0;
    end else begin
      if (aw_hs) aw_have_reg <= 1'b1;
      if (w_hs)  w_have_reg  <= 1'b1;
    end
  end

`ifdef AXI_SRAM_RESPONDER_EXCLUSIVE_EN
  logic             resv_valid_reg;
  logic [IDX_W-1:0] resv_idx_reg;
  logic             resv_hit, resv_clear;

  assign resv_hit = resv_valid_reg && (resv_idx_reg == aw_idx_reg);

  always_comb begin
    wr_en      = 1'b0;
    wr_resp    = AXI_RESP_OKAY;
    resv_clear = 1'b0;
    if (!aw_ok_reg) begin
      wr_resp = AXI_RESP_SLVERR;
    end else if (awlock_reg) begin
      wr_en      = resv_hit;
      wr_resp    = resv_hit ? AXI_RESP_EXOKAY : AXI_RESP_OKAY;
      resv_clear = resv_hit;
    end else begin
      wr_en      = 1'b1;
      resv_clear = resv_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resv_valid_reg <= 1'b0;
    end else if ((state_reg == ST_R_EXEC) && ar_ok_reg && arlock_reg) begin
      resv_valid_reg <= 1'b1;
      resv_idx_reg   <= ar_idx_reg;
    end else if ((state_reg == ST_W_EXEC) && resv_clear) begin
      resv_valid_reg <= 1'b0;
    end
  end
`else
  // Without a monitor every supported write lands and lock only shapes the response.
  always_comb begin
    wr_en   = aw_ok_reg;
    wr_resp = !aw_ok_reg ? AXI_RESP_SLVERR : (awlock_reg ? AXI_RESP_EXOKAY : AXI_RESP_OKAY);
  end
`endif

  assign rd_resp = !ar_ok_reg ? AXI_RESP_SLVERR : (arlock_reg ? AXI_RESP_EXOKAY : AXI_RESP_OKAY);

  // W_EXEC is deliberately not gated by rst so a write in flight still commits.
  assign ram_we   = (state_reg == ST_W_EXEC) && wr_en;
  assign ram_addr = (state_reg == ST_W_EXEC) ? aw_idx_reg : ar_idx_reg;

  axi_sram_responder_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (ram_we),
    .be     (wstrb_reg),
    .addr   (ram_addr),
    .wdata  (wdata_reg),
    .re     (state_reg == ST_R_EXEC),
    .rd_zero(!ar_ok_reg),
    .rdata  (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= 2'b00;
      bid_reg    <= '0;
      rvalid_reg <= 1'b0;
      rresp_reg  <= 2'b00;
      rid_reg    <= '0;
      rlast_reg  <= 1'b0;
    end else begin
      if (state_reg == ST_W_EXEC) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_resp;
        bid_reg    <= awid_reg;
      end else if ((state_reg == ST_B_RESP) && bready) begin
        bvalid_reg <= 1'b0;
      end
      if (state_reg == ST_R_EXEC) begin
        rvalid_reg <= 1'b1;
        rlast_reg  <= 1'b1;
        rresp_reg  <= rd_resp;
        rid_reg    <= arid_reg;
      end else if ((state_reg == ST_R_RESP) && rready) begin
        rvalid_reg <= 1'b0;
        rlast_reg  <= 1'b0;
      end
    end
  end

  assign bvalid = bvalid_reg;
  assign bresp  = bresp_reg;
  assign bid    = bid_reg;
  assign rvalid = rvalid_reg;
  assign rresp  = rresp_reg;
  assign rid    = rid_reg;
  assign rlast  = rlast_reg;

endmodule

// File: doc/axi_sram_responder.md
# axi_sram_responder

AXI4 subordinate that fronts a local word-addressed SRAM and answers the single-beat, lock-capable requests issued by the core's AXI load/store master. It carries an exclusive-access monitor, so LR/SC and read-modify-write AMOs from that master complete with correct EXOKAY/OKAY results. It sits on the far side of the core's external AXI port, as scratchpad memory or as a simulation/bring-up memory model.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 2.
- ID_W, 1: AXI ID width; IDs are echoed unchanged.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- awvalid/awready  in/out  1  write-address handshake
- awaddr  in  32  byte address; awid in ID_W; awlen in 8; awburst in 2; awlock in 1
- wvalid/wready  in/out  1  write-data handshake; wdata in 32; wstrb in 4
- bvalid/bready  out/in  1  write response; bresp out 2; bid out ID_W
- arvalid/arready  in/out  1  read-address handshake
- araddr  in  32; arid in ID_W; arlen in 8; arburst in 2; arlock in 1
- rvalid/rready  out/in  1  read response; rdata out 32; rresp out 2; rid out ID_W; rlast out 1

## Operation
- Word index is addr[2+log2(DEPTH_WORDS)-1:2]. Higher address bits are ignored, so the address space aliases. Bits [1:0] are ignored.
- Only one transaction is in flight at a time. The states are:
  - IDLE: awready=1, wready=1, arready=~awvalid&~wvalid, so writes win on a same-cycle collision. Handshaking AW and W together goes to W_EXEC. Handshaking only one of them goes to W_COLLECT with that channel latched. An AR handshake latches the request and goes to R_EXEC.
  - W_COLLECT: ready is asserted only for the missing channel. When it handshakes, go to W_EXEC.
  - W_EXEC: perform the SRAM write if it is permitted, compute bresp, go to B_RESP.
  - B_RESP: bvalid=1 and bid=the latched awid. When bvalid&bready, go to IDLE.
  - R_EXEC: SRAM read is issued. Go to R_RESP.
  - R_RESP: rvalid=1, rlast=1, rid=the latched arid. When rvalid&rready, go to IDLE.
- Unsupported requests are those with len≠0 or burst≠INCR(01), except that burst=FIXED(00) is accepted because the master drives awburst/arburst as 0.
  - Unsupported write: no write, bresp=SLVERR (10).
  - Unsupported read: rdata=0, rresp=SLVERR.
- Exclusive monitor: one reservation register (valid, index).
  - Exclusive read (arlock=1): sets the reservation to its index, overwriting any previous one. Returns rresp=EXOKAY (01).
  - Exclusive write (awlock=1) when the reservation is valid and the index matches: write performed under wstrb, bresp=EXOKAY, reservation cleared.
  - Exclusive write otherwise: no write, bresp=OKAY (00). The reservation is cleared if the index matches, and left unchanged if it does not.
  - Non-exclusive write: always performed, bresp=OKAY. It clears the reservation on an index match, even when wstrb=0.
  - Non-exclusive read: rresp=OKAY. Leaves the reservation unchanged.
- Byte lanes with wstrb[i]=0 are not modified.

## Timing
- Readies are combinational from the state. All other outputs are registered.
- Read latency: AR handshake at cycle 0, rvalid high at cycle 2. Back-to-back reads with rready=1 sustain one read per 3 cycles.
- Write latency: last of the AW/W handshakes at cycle 0, bvalid high at cycle 2. The written data is visible to a read whose AR handshakes at cycle ≥2.
- bvalid/rvalid remain high with stable payload until the corresponding ready is sampled high.
- A write issued in W_EXEC and a reservation update occur in the same cycle. A following exclusive read sees the updated reservation.
- Reset values: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, bid=0, rid=0, rlast=0. The state returns to IDLE and the reservation becomes invalid. SRAM contents are not reset.
- Reset mid-transaction abandons the transaction; no response is issued for it. A write whose W_EXEC cycle coincides with rst is still committed to the SRAM.

## Configuration
- AXI_SRAM_RESPONDER_EXCLUSIVE_EN defined: the exclusive monitor is implemented as described above.
- Undefined: no reservation register; the awlock and arlock inputs are ignored for all side effects.
  - Every supported write is performed.
  - Locked requests respond EXOKAY. Unlocked requests respond OKAY.
  - This gives single-master correctness only, and the master's SC/AMO retry loop always terminates.

## Structure
- The shared riscv_types package holds the AXI response codes (OKAY=00, EXOKAY=01, SLVERR=10) and the burst code constants.
- The state enum is local to the module.
- Sub-module axi_sram_responder_ram: single-port byte-enable SRAM of DEPTH_WORDS×32 with 1-cycle registered read, inferable as block RAM.

## Test plan
- Write 0xDEADBEEF to 0x10 with wstrb=1111, then read 0x10: bresp=00 at cycle 2, rdata=0xDEADBEEF, rresp=00, rlast=1.
- Partial write wstrb=0010, wdata=0x0000AB00 over 0x11223344 at 0x20: a read returns 0x1122AB44.
- Exclusive read of 0x40, then exclusive write 0x5: bresp=01 and memory holds 5.
  - A second exclusive write to 0x40: bresp=00, memory still 5.
- Exclusive read of 0x40, normal write 0x7 to 0x40, exclusive write 0x9: the normal write gives bresp=00 and memory holds 7; the exclusive write gives bresp=00 and memory stays 7.
- W presented 3 cycles before AW, with bready held low 4 cycles: bvalid stays high with stable bresp/bid, and arready stays 0 until the B handshake.
- arlen=3 read: rresp=10, rdata=0. Assert rst while in R_RESP: rvalid=0 the next cycle, reservation invalid, and the next exclusive write gets bresp=00.
